otter_fetch_unit: RTL and testbench

Instruction-fetch front end for the pipelined OTTER core. It owns the program counter and drives memory read port 1, which has one cycle of synchronous read latency. Returned instructions are buffered in a small prefetch queue, and the queue delivers {IR, PC, PC+4} to the decode stage through a valid/ready handshake. A redirect from the execute stage (jump, taken branch, trap) flushes the queue and any fetch still in flight.

---
 rtl/otter_pkg.sv | 30 +++
 rtl/otter_fetch_unit_if.sv | 27 ++
 rtl/otter_fetch_unit_chk.sv | 20 ++
 rtl/otter_sync_fifo.sv | 61 ++++++
 rtl/otter_fetch_unit.sv | 109 ++++++++++
 tb/tb_otter_fetch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER definitions: reset vector, instruction encodings and the
// fetch queue entry format used between fetch and decode.
package otter_pkg;

  localparam logic [31:0] OTTER_RESET_VEC = 32'h0000_0000;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYS    = 7'b1110011
  } opcode_t;

  typedef struct packed {
    logic [24:0] fields;
    opcode_t     opcode;
  } instr_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } if_entry_t;

endpackage

// File: rtl/otter_fetch_unit_if.sv
// Bundle of the fetch unit's redirect, memory port 1 and decode handshake
// signals. The fetch unit takes the master side; memory/decode/execute the slave.
interface otter_fetch_unit_if;
  import otter_pkg::*;

  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        MEM_RDEN1;
  logic [13:0] MEM_ADDR1;
  logic [31:0] MEM_DOUT1;
  logic        IF_VALID;
  logic        IF_READY;
  logic [31:0] IF_IR;
  logic [31:0] IF_PC;
  logic [31:0] IF_PC_INC;

  modport master (
    input  REDIRECT, REDIRECT_PC, MEM_DOUT1, IF_READY,
    output MEM_RDEN1, MEM_ADDR1, IF_VALID, IF_IR, IF_PC, IF_PC_INC
  );

  modport slave (
    output REDIRECT, REDIRECT_PC, MEM_DOUT1, IF_READY,
    input  MEM_RDEN1, MEM_ADDR1, IF_VALID, IF_IR, IF_PC, IF_PC_INC
  );

endinterface

// File: rtl/otter_fetch_unit_chk.sv
// Invariant checks for the fetch queue: occupancy bound and no overflow push.
module otter_fetch_unit_chk #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input logic          clk,
  input logic          rst_n,
  input logic [CW-1:0] count,
  input logic          push,
  input logic          pop,
  input logic          full
);

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop));

endmodule

// File: rtl/otter_sync_fifo.sv
// Small synchronous FIFO with flush. Occupancy is exported so the owner can
// run credit-based flow control; push/pop at the same time keep count steady.
module otter_sync_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  // Pointer and occupancy update; flush overrides any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; a write during flush is dropped along with the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == CW'(0));
  assign full  = (count_r == CW'(DEPTH));

endmodule

// File: rtl/otter_fetch_unit.sv
// OTTER instruction fetch front end: owns the PC, issues reads to memory
// port 1 (one cycle latency), buffers returns in a prefetch queue and hands
// {IR, PC, PC+4} to decode. A redirect flushes the queue and the in-flight read.
module otter_fetch_unit
  import otter_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_VEC = OTTER_RESET_VEC
) (
  input logic                 CLK,
  input logic                 RST_N,
  otter_fetch_unit_if.master  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0] fetch_pc_r;
  logic        inflight_r;
  logic [31:0] inflight_pc_r;

  logic [31:0] issue_addr_s;
  logic [CW:0] credit_s;
  logic        issue_s;
  logic        push_s;
  logic        pop_s;
  logic        valid_s;
  logic [CW-1:0] count_s;
  logic        fifo_empty_s;
  logic        fifo_full_s;
  if_entry_t   push_entry_s;
  if_entry_t   head_entry_s;

  // Per-cycle issue, capture and dequeue decisions. Credits count both
  // queued entries and the read in flight so a return always has a slot.
  always_comb begin
    credit_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};
    if (bus.REDIRECT) begin
      issue_addr_s = bus.REDIRECT_PC & 32'hFFFF_FFFC;
    end else begin
      issue_addr_s = fetch_pc_r;
    end
    issue_s = RST_N && (bus.REDIRECT || (credit_s < (CW + 1)'(DEPTH)));
    push_s  = inflight_r && !bus.REDIRECT;
    valid_s = RST_N && !fifo_empty_s && !bus.REDIRECT;
    pop_s   = valid_s && bus.IF_READY;
  end

  assign push_entry_s = '{ir: bus.MEM_DOUT1, pc: inflight_pc_r};

  // Memory and decode outputs; address and data are parked during reset.
  always_comb begin
    bus.MEM_RDEN1 = issue_s;
    bus.IF_VALID  = valid_s;
    if (RST_N) begin
      bus.MEM_ADDR1 = issue_addr_s[15:2];
      bus.IF_IR     = head_entry_s.ir;
      bus.IF_PC     = head_entry_s.pc;
      bus.IF_PC_INC = head_entry_s.pc + 32'd4;
    end else begin
      bus.MEM_ADDR1 = RESET_VEC[15:2];
      bus.IF_IR     = 32'd0;
      bus.IF_PC     = 32'd0;
      bus.IF_PC_INC = 32'd0;
    end
  end

  // Program counter and in-flight read tracking.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_pc_r    <= RESET_VEC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= RESET_VEC;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        fetch_pc_r    <= issue_addr_s + 32'd4;
        inflight_pc_r <= issue_addr_s;
      end
    end
  end

  otter_sync_fifo #(
    .WIDTH ($bits(if_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push_s),
    .pop   (pop_s),
    .flush (bus.REDIRECT),
    .wdata (push_entry_s),
    .rdata (head_entry_s),
    .count (count_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  otter_fetch_unit_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clk   (CLK),
    .rst_n (RST_N),
    .count (count_s),
    .push  (push_s),
    .pop   (pop_s),
    .full  (fifo_full_s)
  );

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Bench for otter_fetch_unit: word-addressed memory model with one cycle
// read latency, scoreboard queue of expected PCs, one task per scenario.
module tb_otter_fetch_unit;
  import otter_pkg::*;

  logic clk;
  logic rst_n;
  logic [31:0] mem_dout;
  logic [31:0] exp_q [$];
  int checks;
  int errors;

  otter_fetch_unit_if bus ();

  otter_fetch_unit #(
    .DEPTH     (4),
    .RESET_VEC (32'h0000_0000)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word at word address a holds 32'h1000_0000 + a.
  function automatic logic [31:0] model_ir(input logic [13:0] waddr);
    return 32'h1000_0000 + {18'd0, waddr};
  endfunction

  always @(posedge clk) begin
    if (bus.MEM_RDEN1 === 1'b1) mem_dout <= model_ir(bus.MEM_ADDR1);
  end
  assign bus.MEM_DOUT1 = mem_dout;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Hold reset for two edges, release 1 time unit after an edge (cycle c0).
  task automatic do_reset(input logic ready);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.REDIRECT = 1'b0;
    bus.REDIRECT_PC = 32'h0;
    bus.IF_READY = ready;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (bus.IF_VALID !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", bus.IF_VALID);
    end
    checks++;
    if (bus.MEM_RDEN1 !== 1'b0) begin
      errors++; $display("FAIL reset_rden: got %b expected 0", bus.MEM_RDEN1);
    end
    checks++;
    if (bus.MEM_ADDR1 !== 14'h0) begin
      errors++; $display("FAIL reset_addr: got %h expected 0000", bus.MEM_ADDR1);
    end
    checks++;
    if (bus.IF_IR !== 32'h0 || bus.IF_PC !== 32'h0 || bus.IF_PC_INC !== 32'h0) begin
      errors++; $display("FAIL reset_data: ir %h pc %h inc %h expected all 0",
                         bus.IF_IR, bus.IF_PC, bus.IF_PC_INC);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset(1'b1);
    settle();
    checks++;
    if (bus.MEM_RDEN1 !== 1'b1 || bus.MEM_ADDR1 !== 14'h0) begin
      errors++; $display("FAIL first_issue: rden %b addr %h expected 1 0000",
                         bus.MEM_RDEN1, bus.MEM_ADDR1);
    end
    for (int i = 0; i < 12; i++) exp_q.push_back(32'(4 * i));
    tick(); settle();
    checks++;
    if (bus.IF_VALID !== 1'b0) begin
      errors++; $display("FAIL stream_latency: valid %b expected 0 one cycle after release", bus.IF_VALID);
    end
    tick();
    for (int n = 0; n < 10; n++) begin
      settle();
      checks++;
      if (bus.IF_VALID !== 1'b1) begin
        errors++; $display("FAIL stream_valid: cycle %0d valid %b expected 1", n, bus.IF_VALID);
      end else begin
        exp_pc = exp_q.pop_front();
        if (bus.IF_PC !== exp_pc || bus.IF_IR !== model_ir(exp_pc[15:2]) ||
            bus.IF_PC_INC !== exp_pc + 32'd4) begin
          errors++; $display("FAIL stream_data: pc %h ir %h inc %h expected pc %h ir %h inc %h",
                             bus.IF_PC, bus.IF_IR, bus.IF_PC_INC, exp_pc,
                             model_ir(exp_pc[15:2]), exp_pc + 32'd4);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    int pulses;
    pulses = 0;
    do_reset(1'b0);
    settle();
    for (int n = 0; n < 10; n++) begin
      if (bus.MEM_RDEN1 === 1'b1) pulses++;
      tick(); settle();
    end
    checks++;
    if (pulses != 4) begin
      errors++; $display("FAIL stall_pulses: got %0d read pulses expected 4", pulses);
    end
    checks++;
    if (bus.IF_VALID !== 1'b1 || bus.MEM_RDEN1 !== 1'b0) begin
      errors++; $display("FAIL stall_full: valid %b rden %b expected 1 0", bus.IF_VALID, bus.MEM_RDEN1);
    end
    for (int i = 0; i < 14; i++) exp_q.push_back(32'(4 * i));
    bus.IF_READY = 1'b1;
    for (int n = 0; n < 12; n++) begin
      checks++;
      if (bus.IF_VALID !== 1'b1) begin
        errors++; $display("FAIL stall_drain_valid: cycle %0d valid %b expected 1", n, bus.IF_VALID);
      end else begin
        exp_pc = exp_q.pop_front();
        if (bus.IF_PC !== exp_pc || bus.IF_IR !== model_ir(exp_pc[15:2])) begin
          errors++; $display("FAIL stall_drain_data: pc %h ir %h expected pc %h ir %h",
                             bus.IF_PC, bus.IF_IR, exp_pc, model_ir(exp_pc[15:2]));
        end
      end
      tick(); settle();
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_pc;
    do_reset(1'b0);
    repeat (4) tick();
    bus.REDIRECT = 1'b1;
    bus.REDIRECT_PC = 32'h100;
    settle();
    checks++;
    if (bus.IF_VALID !== 1'b0 || bus.MEM_RDEN1 !== 1'b1 || bus.MEM_ADDR1 !== 14'h40) begin
      errors++; $display("FAIL redir_cycle: valid %b rden %b addr %h expected 0 1 0040",
                         bus.IF_VALID, bus.MEM_RDEN1, bus.MEM_ADDR1);
    end
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    tick();
    bus.REDIRECT = 1'b0;
    settle();
    checks++;
    if (bus.IF_VALID !== 1'b0) begin
      errors++; $display("FAIL redir_gap: valid %b expected 0", bus.IF_VALID);
    end
    tick(); settle();
    bus.IF_READY = 1'b1;
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (bus.IF_VALID !== 1'b1) begin
        errors++; $display("FAIL redir_valid: cycle %0d valid %b expected 1", n, bus.IF_VALID);
      end else begin
        exp_pc = exp_q.pop_front();
        if (bus.IF_PC !== exp_pc || bus.IF_IR !== model_ir(exp_pc[15:2])) begin
          errors++; $display("FAIL redir_data: pc %h ir %h expected pc %h ir %h",
                             bus.IF_PC, bus.IF_IR, exp_pc, model_ir(exp_pc[15:2]));
        end
      end
      tick(); settle();
    end
  endtask

  task automatic test_unaligned();
    logic [31:0] exp_pc;
    do_reset(1'b1);
    repeat (3) tick();
    bus.REDIRECT = 1'b1;
    bus.REDIRECT_PC = 32'h103;
    settle();
    checks++;
    if (bus.MEM_ADDR1 !== 14'h40) begin
      errors++; $display("FAIL unaligned_addr: got %h expected 0040", bus.MEM_ADDR1);
    end
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    tick();
    bus.REDIRECT = 1'b0;
    tick(); settle();
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (bus.IF_VALID !== 1'b1) begin
        errors++; $display("FAIL unaligned_valid: cycle %0d valid %b expected 1", n, bus.IF_VALID);
      end else begin
        exp_pc = exp_q.pop_front();
        if (bus.IF_PC !== exp_pc || bus.IF_PC_INC !== exp_pc + 32'd4) begin
          errors++; $display("FAIL unaligned_pc: pc %h inc %h expected %h %h",
                             bus.IF_PC, bus.IF_PC_INC, exp_pc, exp_pc + 32'd4);
        end
      end
      tick(); settle();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    do_reset(1'b1);
    repeat (3) tick();
    bus.REDIRECT = 1'b1;
    bus.REDIRECT_PC = 32'h200;
    settle();
    checks++;
    if (bus.MEM_ADDR1 !== 14'h80) begin
      errors++; $display("FAIL b2b_first_addr: got %h expected 0080", bus.MEM_ADDR1);
    end
    tick();
    bus.REDIRECT_PC = 32'h300;
    settle();
    checks++;
    if (bus.MEM_ADDR1 !== 14'hC0 || bus.IF_VALID !== 1'b0) begin
      errors++; $display("FAIL b2b_second: addr %h valid %b expected 00c0 0", bus.MEM_ADDR1, bus.IF_VALID);
    end
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h300 + 32'(4 * i));
    tick();
    bus.REDIRECT = 1'b0;
    settle();
    checks++;
    if (bus.IF_VALID !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: valid %b expected 0", bus.IF_VALID);
    end
    tick(); settle();
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (bus.IF_VALID !== 1'b1) begin
        errors++; $display("FAIL b2b_valid: cycle %0d valid %b expected 1", n, bus.IF_VALID);
      end else begin
        exp_pc = exp_q.pop_front();
        if (bus.IF_PC !== exp_pc || bus.IF_IR !== model_ir(exp_pc[15:2])) begin
          errors++; $display("FAIL b2b_data: pc %h ir %h expected pc %h ir %h",
                             bus.IF_PC, bus.IF_IR, exp_pc, model_ir(exp_pc[15:2]));
        end
      end
      tick(); settle();
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] exp_pc;
    do_reset(1'b1);
    repeat (5) tick();
    settle();
    checks++;
    if (bus.IF_VALID !== 1'b1) begin
      errors++; $display("FAIL areset_pre: valid %b expected 1", bus.IF_VALID);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.IF_VALID !== 1'b0 || bus.MEM_RDEN1 !== 1'b0 || bus.IF_PC !== 32'h0) begin
      errors++; $display("FAIL areset_drop: valid %b rden %b pc %h expected 0 0 0",
                         bus.IF_VALID, bus.MEM_RDEN1, bus.IF_PC);
    end
    tick(); tick();
    rst_n = 1'b1;
    settle();
    checks++;
    if (bus.MEM_RDEN1 !== 1'b1 || bus.MEM_ADDR1 !== 14'h0) begin
      errors++; $display("FAIL areset_restart: rden %b addr %h expected 1 0000",
                         bus.MEM_RDEN1, bus.MEM_ADDR1);
    end
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(4 * i));
    tick(); tick(); settle();
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (bus.IF_VALID !== 1'b1) begin
        errors++; $display("FAIL areset_valid: cycle %0d valid %b expected 1", n, bus.IF_VALID);
      end else begin
        exp_pc = exp_q.pop_front();
        if (bus.IF_PC !== exp_pc || bus.IF_IR !== model_ir(exp_pc[15:2])) begin
          errors++; $display("FAIL areset_data: pc %h ir %h expected pc %h ir %h",
                             bus.IF_PC, bus.IF_IR, exp_pc, model_ir(exp_pc[15:2]));
        end
      end
      tick(); settle();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.REDIRECT = 1'b0;
    bus.REDIRECT_PC = 32'h0;
    bus.IF_READY = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_unaligned();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
